pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit for the fetch stage; successor to the plain pc register.
//  Holds the PC, advances it by STEP on accepted fetches, and takes trap and redirect targets.
//  Adds stall, a valid/ready fetch handshake, misaligned-target trapping and a fetch counter.
//  Optional return-address stack. Feeds instruction memory address and IF/ID pipeline.
// PARAMETERS
//  WIDTH         32            PC / address width in bits
//  STEP          4             byte increment per sequential fetch
//  RESET_VECTOR  {WIDTH{1'b0}} PC value loaded on reset
//  TRAP_VECTOR   32'h00000100  PC value loaded on trap or misaligned redirect
//  RAS_DEPTH     4             return-address-stack entries (power of 2, >=2)
// PORTS
//  clk              in   1      single clock, rising edge
//  reset            in   1      synchronous, active-high
//  stall            in   1      hold PC (no sequential advance)
//  fetch_ready      in   1      downstream accepts pc_out this cycle
//  redirect_valid   in   1      branch/jump taken
//  redirect_target  in   WIDTH  branch/jump destination
//  trap             in   1      exception; jump to TRAP_VECTOR
//  ras_push         in   1      call: push pc_out+STEP (RAS build only)
//  ras_pop          in   1      return: redirect to RAS top (RAS build only)
//  pc_out           out  WIDTH  current fetch PC
//  pc_valid         out  1      pc_out is a valid fetch request
//  misalign_err     out  1      sticky: a misaligned redirect was seen
//  fetch_count      out  32     count of accepted fetches
//  ras_top          out  WIDTH  current RAS top entry (0 when empty / feature off)
// BEHAVIOUR
//  - All state updates on rising clk. Reset (sync, active-high) wins over every other input:
//    pc_out=RESET_VECTOR, pc_valid=0, misalign_err=0, fetch_count=0, RAS emptied, ras_top=0.
//  - pc_valid goes 1 on the first edge with reset low and stays 1 until the next reset.
//  - accept = pc_valid & fetch_ready & ~stall.
//  - Next-PC priority (highest first):
//    trap -> TRAP_VECTOR
//    redirect_valid with target[1:0]!=0 -> TRAP_VECTOR, set misalign_err
//    redirect_valid -> redirect_target
//    ras_pop with RAS non-empty -> ras_top
//    accept -> pc_out+STEP
//    else hold.
//  - Trap and redirect take effect even when stall=1 or fetch_ready=0; latency is 1 cycle.
//  - Sequential advance wraps modulo 2^WIDTH; no overflow flag.
//  - misalign_err is sticky; only reset clears it. trap+misaligned redirect same cycle: PC from trap, err still set.
//  - fetch_count increments by 1 on each accept cycle, wraps at 2^32. A redirect in an accept cycle still counts.
// CONFIGURATION
//  Macro PC_UNIT_RAS_EN.
//  Defined: RAS_DEPTH-entry circular return-address stack, with occupancy counter 0..RAS_DEPTH.
//   - ras_push: stores pc_out+STEP as the new top.
//   - Push when full: overwrites oldest; count saturates at RAS_DEPTH.
//   - ras_pop when empty: ignored, PC follows normal rules, count stays 0.
//   - Push+pop same cycle: PC uses the old top; the top entry is replaced by pc_out+STEP; count unchanged.
//   - Push/pop are ignored on cycles where trap or redirect_valid is asserted.
//  Undefined: ras_push/ras_pop ignored, ras_top tied to 0, no RAS storage.
// TESTING
//  1 reset=1 for 2 cycles, release, fetch_ready=1 -> pc_out 0,0,4,8; pc_valid 0 then 1; fetch_count 0,0,1,2.
//  2 stall=1 at pc_out=0x8 for 3 cycles -> pc_out holds 0x8, fetch_count frozen.
//    Release -> 0xC next cycle.
//  3 redirect_valid=1, target=0x00510190, stall=1 -> pc_out=0x00510190 next cycle.
//    Target 0x00100093 -> pc_out=0x100, misalign_err=1, stays 1 until reset.
//  4 trap=1 with redirect_valid=1, target=0x2000 -> pc_out=0x100.
//    pc_out=0xFFFFFFFC with accept -> pc_out=0x0 (wrap).
//  5 (PC_UNIT_RAS_EN) push at pc_out 0x10,0x20,0x30,0x40,0x50 with RAS_DEPTH=4, then 5 pops
//    -> redirect targets 0x54,0x44,0x34,0x24; 5th pop ignored, PC advances by 4.
//  6 Reset asserted mid-sequence with redirect_valid=1 -> pc_out=RESET_VECTOR, all flags/counters 0, RAS empty.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with stall, handshake, trap/redirect, misalign trap and fetch counter.
// Optional return-address stack enabled by defining PC_UNIT_RAS_EN.
module pc_unit #(
  parameter int WIDTH = 32,
  parameter int STEP = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(32'h0000_0100),
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             fetch_ready,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             trap,
  input  logic             ras_push,
  input  logic             ras_pop,
  output logic [WIDTH-1:0] pc_out,
  output logic             pc_valid,
  output logic             misalign_err,
  output logic [31:0]      fetch_count,
  output logic [WIDTH-1:0] ras_top
);
  logic [WIDTH-1:0] pc_q, pc_d, seq_pc;
  logic valid_q, valid_d, err_q, err_d, accept, misalign, pop_hit;
  logic [31:0] cnt_q, cnt_d;
  assign seq_pc = pc_q + WIDTH'(STEP);
  always_comb begin
    accept = valid_q & fetch_ready & ~stall;
    misalign = redirect_valid & (redirect_target[1:0] != 2'b00);
    pc_d = (trap | misalign) ? TRAP_VECTOR :
           redirect_valid ? redirect_target :
           pop_hit ? ras_top :
           accept ? seq_pc : pc_q;
    valid_d = 1'b1;
    err_d = err_q | misalign;
    cnt_d = cnt_q + 32'(accept);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      valid_q <= valid_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef PC_UNIT_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, wr_idx;
  logic [PW:0] occ_q, occ_d;
  logic push, pop;
  // Circular buffer: a push when full lands on the oldest slot, so only occupancy saturates.
  always_comb begin
    push = ras_push & ~trap & ~redirect_valid;
    pop = ras_pop & ~trap & ~redirect_valid & (occ_q != '0);
    pop_hit = pop;
    ras_top = (occ_q != '0) ? ras_q[ptr_q] : '0;
    wr_idx = pop ? ptr_q : ptr_q + PW'(1);
    ptr_d = (push & pop) ? ptr_q : push ? ptr_q + PW'(1) : pop ? ptr_q - PW'(1) : ptr_q;
    occ_d = (push & pop) ? occ_q :
            push ? ((occ_q == (PW+1)'(RAS_DEPTH)) ? occ_q : occ_q + (PW+1)'(1)) :
            pop ? occ_q - (PW+1)'(1) : occ_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      occ_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      occ_q <= occ_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && push) ras_q[wr_idx] <= seq_pc;
  end
`else
  logic unused_ras;
  assign unused_ras = ras_push ^ ras_pop;
  assign pop_hit = 1'b0;
  assign ras_top = '0;
`endif
  assign pc_out = pc_q;
  assign pc_valid = valid_q;
  assign misalign_err = err_q;
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit (RAS vectors built when PC_UNIT_RAS_EN is defined).
module tb_pc_unit;
  logic clk = 1'b0, reset, stall, fetch_ready, redirect_valid, trap, ras_push, ras_pop;
  logic [31:0] redirect_target, pc_out, fetch_count, ras_top;
  logic pc_valid, misalign_err;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .trap(trap),
    .ras_push(ras_push), .ras_pop(ras_pop), .pc_out(pc_out), .pc_valid(pc_valid),
    .misalign_err(misalign_err), .fetch_count(fetch_count), .ras_top(ras_top)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1; stall = 0; fetch_ready = 0; redirect_valid = 0; trap = 0;
    ras_push = 0; ras_pop = 0; redirect_target = '0;
    step(); step();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_valid", {31'b0, pc_valid}, 32'h0);
    chk("rst_cnt", fetch_count, 32'h0);
    chk("rst_ras", ras_top, 32'h0);
    reset = 0; fetch_ready = 1;
    step();
    chk("t1_pc0", pc_out, 32'h0);
    chk("t1_valid", {31'b0, pc_valid}, 32'h1);
    chk("t1_cnt0", fetch_count, 32'h0);
    step();
    chk("t1_pc4", pc_out, 32'h4);
    chk("t1_cnt1", fetch_count, 32'h1);
    step();
    chk("t1_pc8", pc_out, 32'h8);
    chk("t1_cnt2", fetch_count, 32'h2);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_pc", pc_out, 32'h8);
      chk("t2_hold_cnt", fetch_count, 32'h2);
    end
    stall = 0;
    step();
    chk("t2_pcC", pc_out, 32'hC);
    chk("t2_cnt3", fetch_count, 32'h3);
    stall = 1; redirect_valid = 1; redirect_target = 32'h0051_0190;
    step();
    chk("t3_redir", pc_out, 32'h0051_0190);
    chk("t3_cnt", fetch_count, 32'h3);
    chk("t3_err0", {31'b0, misalign_err}, 32'h0);
    redirect_target = 32'h0010_0093;
    step();
    chk("t3_mis_pc", pc_out, 32'h100);
    chk("t3_err1", {31'b0, misalign_err}, 32'h1);
    redirect_valid = 0; stall = 0;
    step();
    chk("t3_adv", pc_out, 32'h104);
    chk("t3_sticky", {31'b0, misalign_err}, 32'h1);
    chk("t3_cnt4", fetch_count, 32'h4);
    trap = 1; redirect_valid = 1; redirect_target = 32'h2000;
    step();
    chk("t4_trap", pc_out, 32'h100);
    chk("t4_cnt5", fetch_count, 32'h5);
    trap = 0; redirect_target = 32'hFFFF_FFFC;
    step();
    chk("t4_top", pc_out, 32'hFFFF_FFFC);
    chk("t4_cnt6", fetch_count, 32'h6);
    redirect_valid = 0;
    step();
    chk("t4_wrap", pc_out, 32'h0);
    chk("t4_cnt7", fetch_count, 32'h7);
    chk("t4_sticky", {31'b0, misalign_err}, 32'h1);
`ifdef PC_UNIT_RAS_EN
    for (int i = 1; i <= 5; i++) begin
      redirect_valid = 1; redirect_target = 32'(i * 16); stall = 0;
      step();
      chk("t5_setpc", pc_out, 32'(i * 16));
      redirect_valid = 0; ras_push = 1; stall = 1;
      step();
      chk("t5_push_top", ras_top, 32'(i * 16 + 4));
      ras_push = 0;
    end
    ras_pop = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_pop_pc", pc_out, 32'(32'h54 - i * 16));
      chk("t5_pop_top", ras_top, (i == 3) ? 32'h0 : 32'(32'h44 - i * 16));
    end
    stall = 0;
    step();
    chk("t5_empty_pop", pc_out, 32'h28);
    ras_pop = 0;
`else
    ras_push = 1; ras_pop = 1;
    step();
    chk("t5_off_pc", pc_out, 32'h4);
    chk("t5_off_top", ras_top, 32'h0);
    ras_push = 0; ras_pop = 0;
`endif
    ras_push = 1;
    step();
    ras_push = 0; redirect_valid = 1; redirect_target = 32'h3000; reset = 1;
    step();
    chk("t6_pc", pc_out, 32'h0);
    chk("t6_valid", {31'b0, pc_valid}, 32'h0);
    chk("t6_err", {31'b0, misalign_err}, 32'h0);
    chk("t6_cnt", fetch_count, 32'h0);
    chk("t6_ras", ras_top, 32'h0);
    reset = 0; redirect_valid = 0;
    step();
    chk("t6_rel_pc", pc_out, 32'h0);
    chk("t6_rel_valid", {31'b0, pc_valid}, 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
